// File: rtl/ysyx_22041211_ifu_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, read response codes, reset PC.
package ysyx_22041211_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_S_IDLE = 2'd0,
        IFU_S_AR   = 2'd1,
        IFU_S_R    = 2'd2,
        IFU_S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22041211_ifu.sv
// Multi-cycle instruction fetch: one read-address/read-data transaction per instruction, then a
// valid/ready hand-off of {pc, inst, error} to the decoder. Option: YSYX_22041211_IFU_MISALIGN_CHECK_EN.
//
// state      | meaning
// IFU_S_IDLE | one quiet cycle after reset release
// IFU_S_AR   | read request outstanding, arvalid_o high until arready_i
// IFU_S_R    | waiting for read data, rready_o high
// IFU_S_OUT  | instruction presented to decoder until inst_ready_i
module ysyx_22041211_ifu
    import ysyx_22041211_ifu_pkg::*;
#(
    parameter int                  ADDR_LEN = 32,
    parameter int                  DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    input  logic [ADDR_LEN-1:0] pc_next_i,
    output logic                fetch_err_o,
    output logic                misalign_o
);

    ifu_state_e          state_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] inst_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                inst_valid_q;
    logic                fetch_err_q;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
    logic                misalign_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IFU_S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IFU_S_IDLE: begin
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
                    if (pc_q[1:0] != 2'b00) begin
                        state_q      <= IFU_S_OUT;
                        inst_q       <= '0;
                        inst_valid_q <= 1'b1;
                        fetch_err_q  <= 1'b1;
                        misalign_q   <= 1'b1;
                    end else
`endif
                    begin
                        state_q   <= IFU_S_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                IFU_S_AR: begin
                    if (arready_i) begin
                        state_q   <= IFU_S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                IFU_S_R: begin
                    if (rvalid_i) begin
                        state_q      <= IFU_S_OUT;
                        rready_q     <= 1'b0;
                        inst_q       <= rdata_i;
                        fetch_err_q  <= resp_is_err(rresp_i);
                        inst_valid_q <= 1'b1;
                    end
                end
                IFU_S_OUT: begin
                    if (inst_ready_i) begin
                        pc_q <= pc_next_i;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
                        // A misaligned target never reaches memory; present it as an error instead.
                        if (pc_next_i[1:0] != 2'b00) begin
                            inst_q       <= '0;
                            fetch_err_q  <= 1'b1;
                            misalign_q   <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q      <= IFU_S_AR;
                            arvalid_q    <= 1'b1;
                            inst_valid_q <= 1'b0;
                            fetch_err_q  <= 1'b0;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
                            misalign_q   <= 1'b0;
`endif
                        end
                    end
                end
                default: state_q <= IFU_S_IDLE;
            endcase
        end
    end

    assign araddr_o     = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign inst_valid_o = inst_valid_q;
    assign fetch_err_o  = fetch_err_q;
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
    assign misalign_o   = misalign_q;
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Self-checking bench for the instruction fetch unit: table of fetches plus reset/misalign sequences.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] pc_next_i;
    logic        fetch_err_o;
    logic        misalign_o;

    ysyx_22041211_ifu dut (
        .clk         (clk),
        .rst         (rst),
        .araddr_o    (araddr_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .pc_next_i   (pc_next_i),
        .fetch_err_o (fetch_err_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait;
        int          r_wait;
        int          hold;
        logic [31:0] pc_next;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    logic [31:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Plays memory for one fetch and consumes the instruction; all driving/sampling on negedge.
    task automatic run_fetch(input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        while (arvalid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_wait_bound", {31'd0, arvalid_o}, 32'd1);
        if (arvalid_o !== 1'b1) return;
        chk("araddr", araddr_o, exp_pc);
        chk("rready_in_ar", {31'd0, rready_o}, 32'd0);
        for (int i = 0; i < v.ar_wait; i++) begin
            arready_i = 1'b0;
            rvalid_i  = 1'b1;
            rdata_i   = 32'h0BAD_0BAD;
            @(negedge clk);
            chk("ar_held_valid", {31'd0, arvalid_o}, 32'd1);
            chk("ar_held_addr", araddr_o, exp_pc);
            chk("early_rvalid_rready", {31'd0, rready_o}, 32'd0);
            chk("early_rvalid_no_inst", {31'd0, inst_valid_o}, 32'd0);
        end
        rvalid_i  = 1'b0;
        arready_i = 1'b1;
        sb.push_back('{pc: exp_pc, inst: v.rdata, err: (v.rresp != 2'b00)});
        @(negedge clk);
        arready_i = 1'b0;
        chk("r_rready", {31'd0, rready_o}, 32'd1);
        chk("r_arvalid_low", {31'd0, arvalid_o}, 32'd0);
        for (int i = 0; i < v.r_wait; i++) begin
            inst_ready_i = 1'b1;
            pc_next_i    = 32'h1234_5670;
            @(negedge clk);
            chk("r_wait_rready", {31'd0, rready_o}, 32'd1);
            chk("r_wait_no_inst", {31'd0, inst_valid_o}, 32'd0);
            chk("r_wait_pc_kept", pc_o, exp_pc);
        end
        rvalid_i = 1'b1;
        rdata_i  = v.rdata;
        rresp_i  = v.rresp;
        @(negedge clk);
        rvalid_i     = 1'b0;
        rdata_i      = 32'h0;
        rresp_i      = 2'b00;
        inst_ready_i = 1'b0;
        pc_next_i    = 32'h1111_1110;
        chk("out_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("out_rready_low", {31'd0, rready_o}, 32'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("hold_pc", pc_o, exp_pc);
            chk("hold_inst", inst_o, v.rdata);
            chk("hold_no_ar", {31'd0, arvalid_o}, 32'd0);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("sb_pc", pc_o, e.pc);
        chk("sb_inst", inst_o, e.inst);
        chk("sb_err", {31'd0, fetch_err_o}, {31'd0, e.err});
        chk("sb_misalign", {31'd0, misalign_o}, 32'd0);
        inst_ready_i = 1'b1;
        pc_next_i    = v.pc_next;
        @(negedge clk);
        inst_ready_i = 1'b0;
        pc_next_i    = 32'h1111_1110;
        exp_pc       = v.pc_next;
        chk("next_pc", pc_o, exp_pc);
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
        if (v.pc_next[1:0] != 2'b00) begin
            chk("mis_no_ar", {31'd0, arvalid_o}, 32'd0);
            chk("mis_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("mis_err", {31'd0, fetch_err_o}, 32'd1);
            chk("mis_flag", {31'd0, misalign_o}, 32'd1);
            chk("mis_inst", inst_o, 32'h0);
            return;
        end
`endif
        chk("next_err_clear", {31'd0, fetch_err_o}, 32'd0);
        chk("next_valid_low", {31'd0, inst_valid_o}, 32'd0);
        chk("next_arvalid", {31'd0, arvalid_o}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_arvalid"}, {31'd0, arvalid_o}, 32'd0);
        chk({tag, "_rready"}, {31'd0, rready_o}, 32'd0);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid_o}, 32'd0);
        chk({tag, "_pc"}, pc_o, RST_PC);
        chk({tag, "_inst"}, inst_o, 32'h0);
        chk({tag, "_err"}, {31'd0, fetch_err_o}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0013, 2'b00, 0, 0, 5, 32'h8000_0004};
        vecs[1] = '{32'h0010_0093, 2'b00, 3, 0, 0, 32'h8000_0008};
        vecs[2] = '{32'hDEAD_BEEF, 2'b10, 0, 2, 1, 32'h8000_000C};
        vecs[3] = '{32'h0000_0297, 2'b00, 1, 1, 0, 32'hFFFF_FFFC};
        vecs[4] = '{32'h1234_5678, 2'b01, 0, 0, 2, 32'hFFFF_FFFC + 32'd4};
        vecs[5] = '{32'hCAFE_F00D, 2'b11, 2, 0, 0, 32'h8000_0000};
        vecs[6] = '{32'h0000_0013, 2'b00, 0, 0, 0, 32'h8000_0004};
        vecs[7] = '{32'h0041_0113, 2'b00, 0, 0, 0, 32'h8000_0002};

        rst          = 1'b0;
        arready_i    = 1'b0;
        rdata_i      = 32'h0;
        rresp_i      = 2'b00;
        rvalid_i     = 1'b0;
        inst_ready_i = 1'b0;
        pc_next_i    = 32'h0;
        exp_pc       = RST_PC;

        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        chk("idle_quiet", {31'd0, arvalid_o}, 32'd0);
        @(negedge clk);
        chk("first_arvalid", {31'd0, arvalid_o}, 32'd1);
        chk("first_araddr", araddr_o, RST_PC);

        for (int k = 0; k < 7; k++) run_fetch(vecs[k]);

        // Abandon a read in flight: async reset while in the data phase.
        n_wait_ar();
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        chk("pre_reset_rready", {31'd0, rready_o}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async");
        sb.delete();
        exp_pc = RST_PC;
        @(negedge clk);
        rst = 1'b1;
        chk("rel_idle", {31'd0, arvalid_o}, 32'd0);
        @(negedge clk);
        chk("refetch_arvalid", {31'd0, arvalid_o}, 32'd1);
        chk("refetch_addr", araddr_o, RST_PC);
        run_fetch(vecs[6]);

        run_fetch(vecs[7]);
`ifdef YSYX_22041211_IFU_MISALIGN_CHECK_EN
        inst_ready_i = 1'b1;
        pc_next_i    = 32'h8000_0010;
        @(negedge clk);
        inst_ready_i = 1'b0;
        chk("mis_exit_pc", pc_o, 32'h8000_0010);
        chk("mis_exit_flag", {31'd0, misalign_o}, 32'd0);
        chk("mis_exit_err", {31'd0, fetch_err_o}, 32'd0);
        exp_pc = 32'h8000_0010;
`endif
        run_fetch('{32'h0000_0073, 2'b00, 0, 0, 0, 32'h8000_0020});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic n_wait_ar();
        int n;
        n = 0;
        while (arvalid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_seq_ar_bound", {31'd0, arvalid_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
